seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
- Shares one programmable serial pattern detector between N_REQ bit-serial requesters.
- Round-robin arbitration grants one requester at a time. The granted channel streams one frame, ending on its last bit.
- The block flags each pattern match Mealy-style, counts matches per frame, and reports count, channel ID and abort status at frame end.
- Sits between the serial front-end channels and the status/interrupt logic.

Parameters:
- N_REQ, 4, number of requesting channels (2..8)
- PAT_LEN, 4, pattern length in bits (2..16)
- CNT_W, 8, width of per-frame match counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-channel request; held high for the whole frame
- bit_vld  in  N_REQ  per-channel serial bit valid
- bit_in  in  N_REQ  per-channel serial data bit
- bit_last  in  N_REQ  marks final bit of frame, qualified by bit_vld
- pattern  in  PAT_LEN  target pattern; MSB is the first-received bit; sampled at grant
- gnt  out  N_REQ  one-hot grant, registered
- match  out  1  Mealy match flag, combinational from the current granted bit
- done  out  1  one-cycle frame-complete pulse
- done_id  out  clog2(N_REQ)  channel of completed frame
- done_cnt  out  CNT_W  matches in completed frame
- done_abort  out  1  frame ended by req drop, not by bit_last

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE; gnt=0, done=0, done_id=0, done_cnt=0, done_abort=0.
  - Match counter and history cleared.
  - RR pointer = N_REQ-1, so channel 0 has top priority first.
  - Reset mid-frame abandons the frame with no done pulse; gnt drops on that edge.
- FSM states: IDLE, STREAM, REPORT.
- IDLE:
  - If any req is high, the winner is the first set req scanning upward (wrapping) from pointer+1.
  - Next edge: gnt[winner]=1, latch pattern and winner index, clear history, bit count and match counter; go to STREAM.
- STREAM:
  - The only accepted bit each cycle is bit_in[g] with bit_vld[g]=1. Non-granted bit_vld are ignored with no backpressure; requesters must hold bits until they see gnt.
  - History = last PAT_LEN-1 accepted bits; fill counter saturates at PAT_LEN-1.
  - match = bit_vld[g] & fill==PAT_LEN-1 & {history,bit_in[g]}==latched pattern. Matches overlap.
  - On match, the counter increments, saturating at 2^CNT_W-1.
  - bit_vld[g] & bit_last[g] → REPORT, and that bit's match is counted. Latency: done one cycle after the last bit.
  - req[g]=0 without a valid last bit → REPORT with abort=1; any bit that cycle is ignored.
  - bit_vld & bit_last in the same cycle as a req drop counts as a normal end (abort=0).
- REPORT:
  - done=1 for exactly one cycle; done_id/done_cnt/done_abort are valid and held until the next done.
  - gnt deasserts on entry to REPORT. Pointer = granted index. Next state IDLE.
  - Minimum gap between grants is 2 cycles (REPORT, IDLE).
- pattern changes during STREAM have no effect.
- match is 0 outside STREAM.

Optional Feature:
- Macro SEQ_DET_NONOVERLAP_EN.
- Defined: after a match, history and fill are cleared, so the next match needs PAT_LEN fresh bits (non-overlapping detection).
- Undefined: overlapping detection as above.
- Ports are identical in both builds.

Decomposition:
- Package seq_det_pkg holds:
  - state enum {IDLE, STREAM, REPORT}
  - default parameter constants
  - a function computing the index width from N_REQ
- One sub-module, seq_match_core, holds the history shifter, fill counter, comparator and combinational match output. Inputs: clr, vld, bit, pattern.
- Arbiter, FSM and counters stay in seq_det_sched.

Test Plan:
- Overlap detection:
  - Stimulus: pattern=1011; ch0 streams 1,0,1,1,0,1,1 with last on the 7th bit.
  - Response: match on bits 4 and 7; done_id=0, done_cnt=2, done_abort=0.
  - With SEQ_DET_NONOVERLAP_EN: done_cnt=1.
- Round robin:
  - Stimulus: req=0101 held right after reset; each frame is 3 bits.
  - Response: grants go ch0, ch2, ch0, in that order. Each gnt rises 2 cycles after the previous done cycle begins (REPORT, IDLE).
- Abort:
  - Stimulus: ch1 is granted, sends 1,0,1, then drops req.
  - Response: done next cycle with done_id=1, done_cnt=0, done_abort=1; gnt is 0 in that cycle.
- Reset mid-frame:
  - Stimulus: assert reset while ch3 is in STREAM.
  - Response: gnt=0 and done=0 after the edge; the next grant goes to ch0 if ch0 and ch3 both request.
- Saturation:
  - Stimulus: CNT_W=2, pattern=11 (PAT_LEN=2); stream ten 1s.
  - Response: 9 match pulses; done_cnt=3.
- Ignored inputs:
  - Stimulus: toggle pattern mid-frame, and pulse bit_vld on non-granted channels.
  - Response: done_cnt is unchanged versus a clean run.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector scheduler.
// Build option SEQ_DET_NONOVERLAP_EN (see seq_match_core) does not change anything here.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_PAT_LEN = 4;
    localparam int DEF_CNT_W   = 8;

    // Width of a channel index; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history, fill counter and Mealy comparator for one serial stream.
// Define SEQ_DET_NONOVERLAP_EN to restart detection after each match.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               vld,
    input  logic               bit_in,
    input  logic [PAT_LEN-1:0] pattern,
    output logic               match
);

    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist;
    logic [FW-1:0]      fill;
    logic [PAT_LEN-1:0] window;

    assign window = {hist, bit_in};
    assign match  = vld && (fill == FULL) && (window == pattern);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (vld) begin
            hist <= window[PAT_LEN-2:0];
            if (fill != FULL) begin
                fill <= fill + 1'b1;
            end
`ifdef SEQ_DET_NONOVERLAP_EN
            // Consume the matched bits so the next match needs a fresh window.
            if (match) begin
                hist <= '0;
                fill <= '0;
            end
`endif
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin sharing of one serial pattern detector between N_REQ channels.
// Detection mode is selected by SEQ_DET_NONOVERLAP_EN inside seq_match_core.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         bit_vld,
    input  logic [N_REQ-1:0]         bit_in,
    input  logic [N_REQ-1:0]         bit_last,
    input  logic [PAT_LEN-1:0]       pattern,
    output logic [N_REQ-1:0]         gnt,
    output logic                     match,
    output logic                     done,
    output logic [idx_w(N_REQ)-1:0]  done_id,
    output logic [CNT_W-1:0]         done_cnt,
    output logic                     done_abort
);

    localparam int IW = idx_w(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: a channel raises req and holds it for the whole frame; it
    // may only present bits once it sees its gnt bit, and there is no
    // backpressure -- every bit_vld of the granted channel is consumed.
    state_t             state, state_nx;
    logic [IW-1:0]      ptr, gid, win, cand;
    logic               found;
    logic [PAT_LEN-1:0] pat_q;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               sel_req, sel_vld, sel_bit, sel_last;
    logic               accept, core_clr;

    assign sel_req  = req[gid];
    assign sel_vld  = bit_vld[gid];
    assign sel_bit  = bit_in[gid];
    assign sel_last = bit_last[gid];

    // A valid bit in the req-drop cycle only counts if it closes the frame.
    assign accept   = (state == STREAM) && sel_vld && (sel_req || sel_last);
    assign core_clr = (state != STREAM);
    assign cnt_nx   = (match && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;

    seq_match_core #(
        .PAT_LEN(PAT_LEN)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .clr    (core_clr),
        .vld    (accept),
        .bit_in (sel_bit),
        .pattern(pat_q),
        .match  (match)
    );

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = STREAM;
            STREAM:  if ((sel_vld && sel_last) || !sel_req) state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            done       <= 1'b0;
            done_id    <= '0;
            done_cnt   <= '0;
            done_abort <= 1'b0;
            ptr        <= IW'(N_REQ - 1);
            gid        <= '0;
            pat_q      <= '0;
            cnt        <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                        gid   <= win;
                        pat_q <= pattern;
                        cnt   <= '0;
                    end
                end
                STREAM: begin
                    cnt <= cnt_nx;
                    if (state_nx == REPORT) begin
                        gnt        <= '0;
                        done       <= 1'b1;
                        done_id    <= gid;
                        done_cnt   <= cnt_nx;
                        done_abort <= !(sel_vld && sel_last);
                        ptr        <= gid;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: table vectors, corner sequences and
// randomized frames against a queue-based reference model.
module tb_seq_det_sched;

    localparam int N_REQ   = 4;
    localparam int PAT_LEN = 4;
    localparam int CNT_W   = 8;
    localparam int EW      = 1 + 2 + CNT_W;
`ifdef SEQ_DET_NONOVERLAP_EN
    localparam bit NONOV = 1'b1;
`else
    localparam bit NONOV = 1'b0;
`endif
    localparam int SAT_PULSES = NONOV ? 5 : 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [3:0] req, bit_vld, bit_in, bit_last, pattern, gnt;
    logic       match, done, done_abort;
    logic [1:0] done_id;
    logic [7:0] done_cnt;

    logic [1:0] s_req, s_vld, s_bit, s_last, s_pat, s_gnt;
    logic       s_match, s_done, s_done_abort;
    logic [0:0] s_done_id;
    logic [1:0] s_done_cnt;

    seq_det_sched #(.N_REQ(N_REQ), .PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .bit_vld(bit_vld), .bit_in(bit_in),
        .bit_last(bit_last), .pattern(pattern), .gnt(gnt), .match(match), .done(done),
        .done_id(done_id), .done_cnt(done_cnt), .done_abort(done_abort)
    );

    seq_det_sched #(.N_REQ(2), .PAT_LEN(2), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .req(s_req), .bit_vld(s_vld), .bit_in(s_bit),
        .bit_last(s_last), .pattern(s_pat), .gnt(s_gnt), .match(s_match), .done(s_done),
        .done_id(s_done_id), .done_cnt(s_done_cnt), .done_abort(s_done_abort)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got id=%0d cnt=%0d expected no done", done_id, done_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_record", {done_abort, done_id, done_cnt}, mon_e);
                check("gnt_at_done", gnt, 0);
            end
        end
        if (!reset && gnt == '0) check("match_outside_stream", match, 0);
    end

    // ---------------- reference model ----------------
    int   m_ptr;
    int   m_cnt;
    logic [3:0] m_pat;
    logic m_hist[$];
    bit   noise_en = 1'b0;

    function automatic int model_winner(input logic [3:0] r);
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (m_ptr + i) % N_REQ;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic model_bit(input logic b);
        int v;
        m_hist.push_back(b);
        if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
        if (m_hist.size() != PAT_LEN) return 1'b0;
        v = 0;
        foreach (m_hist[i]) v = (v << 1) | int'(m_hist[i]);
        if (v != int'(m_pat)) return 1'b0;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (NONOV) m_hist.delete();
        return 1'b1;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_bit(input int ch, input logic vld, input logic b, input logic last);
        logic exp_m;
        bit_vld = '0;
        bit_in = '0;
        bit_last = '0;
        if (noise_en) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (j != ch) begin
                    bit_vld[j[1:0]]  = 1'($urandom_range(0, 1));
                    bit_in[j[1:0]]   = 1'($urandom_range(0, 1));
                    bit_last[j[1:0]] = 1'($urandom_range(0, 1));
                end
            end
            pattern = 4'($urandom);
        end
        bit_vld[ch[1:0]]  = vld;
        bit_in[ch[1:0]]   = b;
        bit_last[ch[1:0]] = last;
        exp_m = 1'b0;
        if (vld && (req[ch[1:0]] || last)) exp_m = model_bit(b);
        #2;
        check("match", match, exp_m);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [3:0] rmask, input logic [3:0] pat,
                             input logic [15:0] bits, input int n, input bit abort,
                             input bit drop_last, input bit hold, input bit gap,
                             input bit use_tbl, input logic [7:0] tbl_cnt,
                             output logic [3:0] g_seen, output int g_cyc, output int d_cyc);
        int w;
        int t;
        logic [15:0] sh;
        logic lst;
        pattern = pat;
        req = rmask;
        w = model_winner(rmask);
        m_pat = pat;
        m_hist.delete();
        m_cnt = 0;
        t = 0;
        while (gnt == '0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        g_seen = gnt;
        g_cyc = cyc;
        check("grant", gnt, 32'(1) << w);
        m_ptr = w;
        sh = bits << (16 - n);
        for (int k = 0; k < n; k++) begin
            if (gap && $urandom_range(0, 3) == 0) drive_bit(w, 1'b0, 1'b0, 1'b0);
            lst = (k == n - 1) && !abort;
            if (lst && drop_last) req = '0;
            drive_bit(w, 1'b1, sh[15], lst);
            sh = sh << 1;
        end
        if (abort) begin
            req = '0;
            drive_bit(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        exp_q.push_back({abort, 2'(w), use_tbl ? tbl_cnt : 8'(m_cnt)});
        check("done_pulse", done, 1);
        d_cyc = cyc;
        if (!hold) req = '0;
        bit_vld = '0;
        bit_in = '0;
        bit_last = '0;
        @(negedge clk);
        check("done_single_cycle", done, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  rmask;
        logic [3:0]  pat;
        logic [15:0] bits;
        int          n;
        bit          abort;
        bit          drop_last;
        logic [7:0]  exp_ovl;
        logic [7:0]  exp_non;
    } vec_t;

    vec_t tbl[7];
    logic [3:0] rr_exp[3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] gs;
        int gc, dc, prev_dc, t, pulses;

        tbl[0] = '{4'b0001, 4'b1011, 16'b1011011,  7, 1'b0, 1'b0, 8'd2, 8'd1};
        tbl[1] = '{4'b0010, 4'b1011, 16'b101,      3, 1'b1, 1'b0, 8'd0, 8'd0};
        tbl[2] = '{4'b0100, 4'b0000, 16'b000000,   6, 1'b0, 1'b0, 8'd3, 8'd1};
        tbl[3] = '{4'b1000, 4'b1111, 16'b11111111, 8, 1'b0, 1'b0, 8'd5, 8'd2};
        tbl[4] = '{4'b0001, 4'b0110, 16'b0110110,  7, 1'b0, 1'b0, 8'd2, 8'd1};
        tbl[5] = '{4'b0100, 4'b1010, 16'b101,      3, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[6] = '{4'b0010, 4'b1011, 16'b1011,     4, 1'b0, 1'b1, 8'd1, 8'd1};
        rr_exp = '{4'b0001, 4'b0100, 4'b0001};

        req = '0; bit_vld = '0; bit_in = '0; bit_last = '0; pattern = '0;
        s_req = '0; s_vld = '0; s_bit = '0; s_last = '0; s_pat = '0;

        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_done_abort", done_abort, 0);
        check("rst_match", match, 0);
        check("rst_sat_gnt", s_gnt, 0);
        reset = 1'b0;
        m_ptr = N_REQ - 1;

        for (int v = 0; v < 7; v++) begin
            run_frame(tbl[v].rmask, tbl[v].pat, tbl[v].bits, tbl[v].n, tbl[v].abort,
                      tbl[v].drop_last, 1'b0, 1'b0, 1'b1,
                      NONOV ? tbl[v].exp_non : tbl[v].exp_ovl, gs, gc, dc);
        end

        // Round robin with two requesters held high from reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = N_REQ - 1;
        prev_dc = 0;
        for (int f = 0; f < 3; f++) begin
            run_frame(4'b0101, 4'b1111, 16'b000, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,
                      gs, gc, dc);
            check("rr_order", gs, rr_exp[f]);
            if (f > 0) check("rr_gap", gc - prev_dc, 2);
            prev_dc = dc;
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Reset while ch3 is mid-frame.
        req = 4'b1000;
        pattern = 4'b1011;
        t = 0;
        while (gnt == '0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_pre_gnt", gnt, 4'b1000);
        m_pat = 4'b1011;
        m_hist.delete();
        drive_bit(3, 1'b1, 1'b1, 1'b0);
        drive_bit(3, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        req = 4'b1001;
        bit_vld = '0;
        @(negedge clk);
        check("rst_mid_gnt", gnt, 0);
        check("rst_mid_done", done, 0);
        reset = 1'b0;
        m_ptr = N_REQ - 1;
        run_frame(4'b1001, 4'b1011, 16'b1011, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,
                  gs, gc, dc);
        check("rst_mid_next_gnt", gs, 4'b0001);

        // Pattern toggling and foreign bit_vld must not change the result.
        noise_en = 1'b1;
        run_frame(4'b0001, 4'b1011, 16'b1011011, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  NONOV ? 8'd1 : 8'd2, gs, gc, dc);

        // Randomized frames.
        for (int r = 0; r < 30; r++) begin
            run_frame(4'($urandom_range(1, 15)), 4'($urandom), 16'($urandom),
                      $urandom_range(1, 12), ($urandom_range(0, 4) == 0), 1'b0, 1'b0,
                      1'b1, 1'b0, 8'd0, gs, gc, dc);
        end
        noise_en = 1'b0;

        // Counter saturation on a narrow instance.
        s_req = 2'b01;
        s_pat = 2'b11;
        t = 0;
        while (s_gnt == '0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("sat_gnt", s_gnt, 2'b01);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            s_vld = 2'b01;
            s_bit = 2'b01;
            s_last = (k == 9) ? 2'b01 : 2'b00;
            #2;
            if (s_match) pulses++;
            @(negedge clk);
        end
        check("sat_done", s_done, 1);
        check("sat_cnt", s_done_cnt, 3);
        check("sat_abort", s_done_abort, 0);
        check("sat_id", s_done_id, 0);
        check("sat_pulses", pulses, SAT_PULSES);
        s_req = '0;
        s_vld = '0;
        s_last = '0;
        repeat (3) @(negedge clk);

        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
